// File: rtl/sap1_seg7_display.sv
// SAP-1 output register to Basys3 4-digit seven-segment display, hex or decimal.
// Optional macro SAP1_SEG7_HEX_DP_EN lights the dp on digit 1 in hex mode.
module sap1_seg7_display #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned SCAN_W      = 17
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] value,
    input  logic       dec_mode,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       busy
);

    localparam logic [SCAN_W-1:0] TERM = SCAN_W'(REFRESH_DIV - 1);
    localparam logic [6:0]        BLANK = 7'h7F;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

    state_t            state, state_nx;
    logic [7:0]        shadow_val, last_val;
    logic              shadow_dec, last_dec, valid;
    logic [19:0]       dd;
    logic [2:0]        shift_cnt;
    logic [3:0][3:0]   digit;
    logic [3:0]        blank;
    logic              disp_dec;
    logic [SCAN_W-1:0] presc;
    logic [1:0]        idx;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    // One double-dabble step: adjust BCD nibbles >= 5, then shift left.
    function automatic logic [19:0] dabble(input logic [19:0] x);
        logic [19:0] y;
        y = x;
        for (int n = 0; n < 3; n++) begin
            if (y[8+4*n +: 4] >= 4'd5)
                y[8+4*n +: 4] = y[8+4*n +: 4] + 4'd3;
        end
        dabble = {y[18:0], 1'b0};
    endfunction

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!valid || value != last_val || dec_mode != last_dec)
                         state_nx = LOAD;
            LOAD:    state_nx = SHIFT;
            SHIFT:   if (shift_cnt == 3'd7) state_nx = COMMIT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == LOAD) || (state_nx == SHIFT);
        end
    end

    // Conversion datapath; digit registers change only in COMMIT.
    always_ff @(posedge clk) begin
        if (clr) begin
            valid      <= 1'b0;
            last_val   <= 8'd0;
            last_dec   <= 1'b0;
            shadow_val <= 8'd0;
            shadow_dec <= 1'b0;
            dd         <= 20'd0;
            shift_cnt  <= 3'd0;
            digit      <= '0;
            blank      <= 4'hF;
            disp_dec   <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    shadow_val <= value;
                    shadow_dec <= dec_mode;
                    dd         <= {12'd0, value};
                    shift_cnt  <= 3'd0;
                end
                SHIFT: begin
                    dd        <= dabble(dd);
                    shift_cnt <= shift_cnt + 3'd1;
                end
                COMMIT: begin
                    valid    <= 1'b1;
                    last_val <= shadow_val;
                    last_dec <= shadow_dec;
                    disp_dec <= shadow_dec;
                    if (shadow_dec) begin
                        digit <= {4'd0, dd[19:16], dd[15:12], dd[11:8]};
                        blank <= {1'b1, dd[19:16] == 4'd0,
                                  dd[19:16] == 4'd0 && dd[15:12] == 4'd0, 1'b0};
                    end else begin
                        digit <= {8'd0, shadow_val};
                        blank <= 4'b1100;
                    end
                end
                default: ;
            endcase
        end
    end

    // Scan: an/seg latch the current slot at terminal count, then the index advances.
    always_ff @(posedge clk) begin
        if (clr) begin
            presc <= '0;
            idx   <= 2'd0;
            an    <= 4'hF;
            seg   <= BLANK;
        end else if (presc == TERM) begin
            presc <= '0;
            idx   <= idx + 2'd1;
            an    <= ~(4'b0001 << idx);
            seg   <= blank[idx] ? BLANK : glyph(digit[idx]);
        end else begin
            presc <= presc + SCAN_W'(1);
        end
    end

`ifdef SAP1_SEG7_HEX_DP_EN
    always_ff @(posedge clk) begin
        if (clr)
            dp <= 1'b1;
        else if (presc == TERM)
            dp <= !(!disp_dec && idx == 2'd1);
    end
`else
    assign dp = 1'b1;
`endif

endmodule

// File: tb/tb_sap1_seg7_display.sv
// Directed self-checking bench for sap1_seg7_display with REFRESH_DIV=4.
module tb_sap1_seg7_display;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] BL = 7'h7F;
`ifdef SAP1_SEG7_HEX_DP_EN
    localparam logic HEX_DP1 = 1'b0;
`else
    localparam logic HEX_DP1 = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] value;
    logic       dec_mode;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sap1_seg7_display #(.REFRESH_DIV(4), .SCAN_W(3)) dut (
        .clk(clk), .clr(clr), .value(value), .dec_mode(dec_mode),
        .seg(seg), .dp(dp), .an(an), .busy(busy)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Waits for a fresh transition into slot i and returns what it shows.
    task automatic get_slot(input int i, output logic [6:0] s, output logic d, output bit ok);
        logic [3:0] tgt;
        logic [3:0] prev;
        tgt  = ~(4'b0001 << i);
        ok   = 1'b0;
        prev = an;
        for (int n = 0; n < 40 && !ok; n++) begin
            tick(1);
            if (an == tgt && prev != tgt) ok = 1'b1;
            else prev = an;
        end
        s = seg;
        d = dp;
    endtask

    task automatic test_reset;
        int busy_cnt;
        logic [6:0] s;
        logic d;
        bit ok;
        logic [6:0] exp_seg [4];
        exp_seg = '{S0, BL, BL, BL};
        clr = 1'b1; value = 8'h00; dec_mode = 1'b1;
        tick(2);
        checks++; if (seg !== BL)   begin errors++; $display("FAIL reset_seg: got %b expected %b", seg, BL); end
        checks++; if (an !== 4'hF)  begin errors++; $display("FAIL reset_an: got %h expected f", an); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (dp !== 1'b1)  begin errors++; $display("FAIL reset_dp: got %b expected 1", dp); end
        clr = 1'b0;
        busy_cnt = 0;
        for (int k = 1; k <= 15; k++) begin
            tick(1);
            if (busy === 1'b1) busy_cnt++;
            if (k == 3) begin
                checks++; if (an !== 4'hF) begin errors++; $display("FAIL first_an_hold: got %h expected f", an); end
            end
            if (k == 4) begin
                checks++; if (an !== 4'hE) begin errors++; $display("FAIL first_an_slot0: got %h expected e", an); end
            end
        end
        checks++; if (busy_cnt != 9) begin errors++; $display("FAIL busy_pulse_len: got %0d expected 9", busy_cnt); end
        for (int i = 0; i < 4; i++) begin
            get_slot(i, s, d, ok);
            checks++;
            if (!ok || s !== exp_seg[i]) begin
                errors++; $display("FAIL zero_slot%0d: seg=%b expected %b found=%0d", i, s, exp_seg[i], ok);
            end
        end
    endtask

    task automatic test_dec_255;
        logic [6:0] s;
        logic d;
        bit ok;
        logic [6:0] exp_seg [4];
        exp_seg = '{S5, S5, S2, BL};
        value = 8'd255; dec_mode = 1'b1;
        tick(12);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dec255_busy_done: got %b expected 0", busy); end
        for (int i = 0; i < 4; i++) begin
            get_slot(i, s, d, ok);
            checks++;
            if (!ok || s !== exp_seg[i]) begin
                errors++; $display("FAIL dec255_slot%0d: seg=%b expected %b found=%0d", i, s, exp_seg[i], ok);
            end
            checks++;
            if (d !== 1'b1) begin errors++; $display("FAIL dec255_dp%0d: got %b expected 1", i, d); end
        end
    endtask

    task automatic test_hex;
        logic [6:0] s;
        logic d;
        bit ok;
        logic [6:0] exp_seg [4];
        logic       exp_dp  [4];
        exp_seg = '{S7, SA, BL, BL};
        exp_dp  = '{1'b1, HEX_DP1, 1'b1, 1'b1};
        value = 8'hA7; dec_mode = 1'b0;
        tick(12);
        for (int i = 0; i < 4; i++) begin
            get_slot(i, s, d, ok);
            checks++;
            if (!ok || s !== exp_seg[i]) begin
                errors++; $display("FAIL hex_slot%0d: seg=%b expected %b found=%0d", i, s, exp_seg[i], ok);
            end
            checks++;
            if (d !== exp_dp[i]) begin errors++; $display("FAIL hex_dp%0d: got %b expected %b", i, d, exp_dp[i]); end
        end
    endtask

    task automatic test_midchange;
        logic [6:0] s;
        logic d;
        bit ok;
        logic [6:0] exp_seg [4];
        exp_seg = '{S5, S0, S1, BL};
        value = 8'd5; dec_mode = 1'b1;
        tick(4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_shift3: got %b expected 1", busy); end
        value = 8'd105;
        tick(6);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_commit: got %b expected 0", busy); end
        tick(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_idle: got %b expected 0", busy); end
        tick(1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_reload: got %b expected 1", busy); end
        tick(12);
        for (int i = 0; i < 4; i++) begin
            get_slot(i, s, d, ok);
            checks++;
            if (!ok || s !== exp_seg[i]) begin
                errors++; $display("FAIL mid105_slot%0d: seg=%b expected %b found=%0d", i, s, exp_seg[i], ok);
            end
        end
    endtask

    task automatic test_clr_midshift;
        logic [6:0] s;
        logic d;
        bit ok;
        logic [6:0] exp_seg [4];
        exp_seg = '{S0, S0, S2, BL};
        value = 8'd200; dec_mode = 1'b1;
        tick(5);
        clr = 1'b1;
        tick(1);
        checks++; if (seg !== BL)    begin errors++; $display("FAIL clr_seg: got %b expected %b", seg, BL); end
        checks++; if (an !== 4'hF)   begin errors++; $display("FAIL clr_an: got %h expected f", an); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy: got %b expected 0", busy); end
        checks++; if (dp !== 1'b1)   begin errors++; $display("FAIL clr_dp: got %b expected 1", dp); end
        clr = 1'b0;
        tick(14);
        for (int i = 0; i < 4; i++) begin
            get_slot(i, s, d, ok);
            checks++;
            if (!ok || s !== exp_seg[i]) begin
                errors++; $display("FAIL clr200_slot%0d: seg=%b expected %b found=%0d", i, s, exp_seg[i], ok);
            end
        end
    endtask

    task automatic test_scan_wrap;
        logic [3:0] prev;
        logic [3:0] exp_an [2];
        int cnt;
        bit found;
        exp_an = '{4'hE, 4'hD};
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            prev = an;
            tick(1);
            if (an == 4'h7 && prev != 4'h7) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL scan_find_slot3: got %h expected 7", an); end
        for (int j = 0; j < 2; j++) begin
            prev = an;
            cnt = 0;
            for (int n = 0; n < 20 && an == prev; n++) begin
                tick(1);
                cnt++;
            end
            checks++; if (cnt != 4) begin errors++; $display("FAIL scan_period%0d: got %0d expected 4", j, cnt); end
            checks++; if (an !== exp_an[j]) begin errors++; $display("FAIL scan_order%0d: got %h expected %h", j, an, exp_an[j]); end
        end
    endtask

    initial begin
        clr = 1'b1; value = 8'h00; dec_mode = 1'b1;
        test_reset();
        test_dec_255();
        test_hex();
        test_midchange();
        test_clr_midshift();
        test_scan_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
